// File: rtl/flexbex_ibex_pkg.sv
// Shared definitions for the flexbex ibex front end: realigner state encoding
// and the opcode LSB pattern that marks a full-width (non-compressed) instruction.
package flexbex_ibex_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    HOLD    = 2'd1,
    SKIP    = 2'd2
  } realign_state_e;

  localparam logic [1:0] OPCODE_32B_LSBS = 2'b11;

endpackage

// File: rtl/flexbex_ibex_instr_realigner.sv
// Turns the word-aligned prefetch stream into one instruction per handshake,
// handling RVC halves, word-straddling 32-bit instructions and halfword branch targets.
module flexbex_ibex_instr_realigner
  import flexbex_ibex_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_rdata_i,
  input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [31:0]           instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  instr_is_compressed_o
);

  realign_state_e        state_q, state_d;
  logic [15:0]           hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
  logic [ADDR_WIDTH-1:0] word_base;
  logic [ADDR_WIDTH-1:0] upper_addr;
  logic                  accept;
  logic                  unused_bits;

  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != OPCODE_32B_LSBS;
  endfunction

  assign word_base  = {fetch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign upper_addr = word_base + ADDR_WIDTH'(2);
  assign accept     = instr_valid_o & instr_ready_i;

  // Only bit 1 of the branch target and the word base of the fetch address matter.
  assign unused_bits = ^{fetch_addr_i[1:0], branch_addr_i[ADDR_WIDTH-1:2], branch_addr_i[0]};

  always_comb begin
    state_d               = state_q;
    hold_d                = hold_q;
    hold_addr_d           = hold_addr_q;
    fetch_ready_o         = 1'b0;
    instr_valid_o         = 1'b0;
    instr_rdata_o         = 32'h0;
    instr_addr_o          = '0;
    instr_is_compressed_o = 1'b0;

    if (!rst_n) begin
      state_d = ALIGNED;
    end else if (branch_i) begin
      state_d = branch_addr_i[1] ? SKIP : ALIGNED;
    end else begin
      unique case (state_q)
        ALIGNED: begin
          instr_valid_o = fetch_valid_i;
          instr_addr_o  = word_base;
          if (is_compressed(fetch_rdata_i[15:0])) begin
            instr_rdata_o         = {16'h0, fetch_rdata_i[15:0]};
            instr_is_compressed_o = 1'b1;
            if (accept) begin
              fetch_ready_o = 1'b1;
              hold_d        = fetch_rdata_i[31:16];
              hold_addr_d   = upper_addr;
              state_d       = HOLD;
            end
          end else begin
            instr_rdata_o = fetch_rdata_i;
            fetch_ready_o = instr_ready_i;
          end
        end

        HOLD: begin
          instr_addr_o = hold_addr_q;
          if (is_compressed(hold_q)) begin
            instr_valid_o         = 1'b1;
            instr_rdata_o         = {16'h0, hold_q};
            instr_is_compressed_o = 1'b1;
            if (accept) begin
              state_d = ALIGNED;
            end
          end else begin
            // Lower half of the new word completes the stored upper half.
            instr_valid_o = fetch_valid_i;
            instr_rdata_o = {fetch_rdata_i[15:0], hold_q};
            if (accept) begin
              fetch_ready_o = 1'b1;
              hold_d        = fetch_rdata_i[31:16];
              hold_addr_d   = upper_addr;
            end
          end
        end

        SKIP: begin
          fetch_ready_o = fetch_valid_i;
          if (fetch_valid_i) begin
            hold_d      = fetch_rdata_i[31:16];
            hold_addr_d = upper_addr;
            state_d     = HOLD;
          end
        end

        default: begin
          state_d = ALIGNED;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ALIGNED;
      hold_q      <= 16'h0;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
    end
  end

endmodule

// File: tb/tb_flexbex_ibex_instr_realigner.sv
// Bench for the instruction realigner: a word-source queue feeds the fetch side and
// a scoreboard of expected instructions is checked on every IF/ID handshake.
module tb_flexbex_ibex_instr_realigner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_ready_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        instr_is_compressed_o;

  always #5 clk = ~clk;

  flexbex_ibex_instr_realigner #(.ADDR_WIDTH(32)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .branch_i              (branch_i),
    .branch_addr_i         (branch_addr_i),
    .fetch_valid_i         (fetch_valid_i),
    .fetch_rdata_i         (fetch_rdata_i),
    .fetch_addr_i          (fetch_addr_i),
    .fetch_ready_o         (fetch_ready_o),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i),
    .instr_rdata_o         (instr_rdata_o),
    .instr_addr_o          (instr_addr_o),
    .instr_is_compressed_o (instr_is_compressed_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fword_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        comp;
  } instr_t;

  fword_t fq[$];
  instr_t eq[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  bit     rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    fword_t w;
    w.addr = a;
    w.data = d;
    fq.push_back(w);
  endtask

  task automatic push_instr(input logic [31:0] a, input logic [31:0] d);
    instr_t e;
    e.addr  = a;
    e.rdata = d;
    e.comp  = (d[1:0] != 2'b11);
    eq.push_back(e);
  endtask

  task automatic drive_fetch();
    if (fq.size() > 0) begin
      fetch_valid_i = 1'b1;
      fetch_rdata_i = fq[0].data;
      fetch_addr_i  = fq[0].addr;
    end else begin
      fetch_valid_i = 1'b0;
      fetch_rdata_i = 32'h0;
      fetch_addr_i  = 32'h0;
    end
    if (rand_ready) instr_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  // Called at the falling edge: score any handshake on either side.
  task automatic score();
    instr_t e;
    fword_t w;
    if (instr_valid_o && instr_ready_i) begin
      if (eq.size() == 0) begin
        check("spurious_instr_valid", {63'h0, instr_valid_o}, 64'h0);
      end else begin
        e = eq.pop_front();
        $display("instr @0x%08h data 0x%08h comp %0d (exp @0x%08h 0x%08h)",
                 instr_addr_o, instr_rdata_o, instr_is_compressed_o, e.addr, e.rdata);
        check("instr_rdata", {32'h0, instr_rdata_o}, {32'h0, e.rdata});
        check("instr_addr", {32'h0, instr_addr_o}, {32'h0, e.addr});
        check("instr_comp", {63'h0, instr_is_compressed_o}, {63'h0, e.comp});
      end
    end
    if (fetch_valid_i && fetch_ready_o) w = fq.pop_front();
  endtask

  task automatic cycle();
    drive_fetch();
    @(negedge clk);
    score();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input int budget, input int exp_cycles);
    int n;
    n = 0;
    while ((eq.size() > 0 || fq.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(eq.size() + fq.size()), 64'h0);
    if (exp_cycles >= 0) check({tag, "_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    logic [15:0] hw[$];
    logic [31:0] r;
    logic [31:0] base;

    rst_n         = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    instr_ready_i = 1'b1;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00000013;
    fetch_addr_i  = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_valid", {63'h0, instr_valid_o}, 64'h0);
    check("rst_fetch_ready", {63'h0, fetch_ready_o}, 64'h0);
    check("rst_instr_rdata", {32'h0, instr_rdata_o}, 64'h0);
    check("rst_instr_addr", {32'h0, instr_addr_o}, 64'h0);
    check("rst_instr_comp", {63'h0, instr_is_compressed_o}, 64'h0);
    rst_n = 1'b1;
    fetch_valid_i = 1'b0;

    // Aligned 32-bit stream, zero latency
    push_word(32'h100, 32'h00000013); push_instr(32'h100, 32'h00000013);
    push_word(32'h104, 32'h00100093); push_instr(32'h104, 32'h00100093);
    run("aligned", 10, 2);

    // Two compressed instructions in one word
    push_word(32'h200, 32'h45014501);
    push_instr(32'h200, 32'h4501); push_instr(32'h202, 32'h4501);
    run("two_rvc", 10, 2);

    // 32-bit instruction straddling a word boundary
    push_word(32'h300, 32'h00134501); push_word(32'h304, 32'h45010000);
    push_instr(32'h300, 32'h4501); push_instr(32'h302, 32'h00000013);
    push_instr(32'h306, 32'h4501);
    run("straddle", 10, 3);

    // Branch to a halfword target; a stale word during the branch must not be taken
    push_word(32'h10, 32'h11111111);
    branch_i = 1'b1;
    branch_addr_i = 32'h402;
    cycle();
    branch_i = 1'b0;
    check("branch_no_consume", 64'(fq.size()), 64'h1);
    fq.delete();
    push_word(32'h400, 32'h4505FFFF); push_instr(32'h402, 32'h4505);
    run("branch_skip", 10, 2);

    // Back-pressure in HOLD, then a flush
    push_word(32'h600, 32'h45014501); push_word(32'h604, 32'h00000013);
    push_instr(32'h600, 32'h4501); push_instr(32'h602, 32'h4501);
    cycle();
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_fetch();
      @(negedge clk);
      check("bp_valid", {63'h0, instr_valid_o}, 64'h1);
      check("bp_rdata", {32'h0, instr_rdata_o}, 64'h4501);
      check("bp_addr", {32'h0, instr_addr_o}, 64'h602);
      check("bp_fetch_ready", {63'h0, fetch_ready_o}, 64'h0);
      score();
      @(posedge clk);
      #1;
    end
    instr_ready_i = 1'b1;
    branch_i = 1'b1;
    branch_addr_i = 32'h604;
    drive_fetch();
    @(negedge clk);
    check("flush_valid", {63'h0, instr_valid_o}, 64'h0);
    check("flush_fetch_ready", {63'h0, fetch_ready_o}, 64'h0);
    @(posedge clk);
    #1;
    branch_i = 1'b0;
    eq.delete();
    push_instr(32'h604, 32'h00000013);
    run("after_flush", 10, 1);

    // Reset while a straddling half is stored
    push_word(32'h700, 32'h00134501); push_instr(32'h700, 32'h4501);
    cycle();
    drive_fetch();
    @(negedge clk);
    check("straddle_wait_valid", {63'h0, instr_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive_fetch();
    @(negedge clk);
    check("midrst_valid", {63'h0, instr_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_word(32'h500, 32'h00000013); push_instr(32'h500, 32'h00000013);
    run("after_reset", 10, 1);

    // Random mix of compressed/full instructions with random back-pressure
    base = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        r[1:0] = 2'($urandom_range(0, 2));
        push_instr(base + 32'(2 * hw.size()), {16'h0, r[15:0]});
        hw.push_back(r[15:0]);
      end else begin
        r[1:0] = 2'b11;
        push_instr(base + 32'(2 * hw.size()), r);
        hw.push_back(r[15:0]);
        hw.push_back(r[31:16]);
      end
    end
    if (hw.size() % 2 == 1) begin
      push_instr(base + 32'(2 * hw.size()), 32'h0001);
      hw.push_back(16'h0001);
    end
    for (int i = 0; i < hw.size() / 2; i++) begin
      push_word(base + 32'(4 * i), {hw[2 * i + 1], hw[2 * i]});
    end
    rand_ready = 1'b1;
    run("random", 600, -1);
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
